data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
Single-port data memory plus a small MMIO window, sitting directly downstream of the load/store unit.
- Consumes the LSU's unaligned store requests (size-encoded write enable, raw rs2 data, byte address) and performs byte-lane steering.
- Returns read data right-aligned one cycle after the address, so the LSU's sign/zero extension can operate on bits [7:0]/[15:0].
- Also hosts a free-running 64-bit cycle counter and a GPIO output register.

Parameters:
DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, >= 2.
MMIO_BIT, 31, address bit selecting the MMIO window (1 = MMIO, 0 = RAM).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
d_we  input  2  store size: 00 none, 01 byte, 10 half, 11 word
d_addr  input  32  byte address, sampled every cycle
d_wr_data  input  32  store data, unaligned (byte in [7:0], half in [15:0])
d_rd_data  output  32  right-aligned read data for the address presented in the previous cycle
misalign_err  output  1  one-cycle pulse: previous cycle's store was misaligned and was dropped
gpio_out  output  32  GPIO output register
cycle_cnt  output  64  live cycle counter (debug/observation)

Behaviour:
- Reset values (async, rst high):
  - d_rd_data=0, misalign_err=0, gpio_out=0, cycle_cnt=0.
  - Internal offset register=0, shadow register=0.
  - RAM contents are not reset.
- Address decode:
  - d_addr[MMIO_BIT]=0 selects RAM, word index d_addr[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so RAM aliases.
  - d_addr[MMIO_BIT]=1 selects MMIO register d_addr[3:2]:
    - 0: GPIO_OUT, read/write.
    - 1: CYCLE_LO, read-only.
    - 2: CYCLE_HI, read-only; returns the shadow register.
    - 3: reserved; reads 0, writes ignored.
  - All other MMIO address bits are ignored.
- Store lane steering, with off=d_addr[1:0]:
  - byte: lane off <= d_wr_data[7:0].
  - half: lanes {off[1],0} and {off[1],1} <= d_wr_data[15:0], little-endian.
  - word: all lanes <= d_wr_data.
  - Unselected lanes are unchanged.
  - Applies identically to RAM and GPIO_OUT.
- Misalignment:
  - A half with off[0]=1, or a word with off!=0, is a misaligned store.
  - Misaligned stores write nothing, to RAM or MMIO.
  - misalign_err=1 in the following cycle only, then returns to 0 unless another misaligned store occurs.
  - Loads carry no size, so misaligned loads are not detected: returned data is the shifted word with vacated upper bytes zero.
- Writes take effect at the clk edge that samples them.
  - Stores to CYCLE_LO, CYCLE_HI or the reserved register are ignored and raise no error.
  - A GPIO_OUT store updates gpio_out at that edge.
- Read path:
  - Every cycle the selected word (RAM word or MMIO register) and off are registered.
  - In cycle N+1, d_rd_data = selected_word >> (8*off_captured), zero-filled.
  - Latency is exactly 1 cycle, with no stall and no read strobe.
  - Reads occur during store cycles too. The value is don't-care to the LSU but must still follow the rule above.
- Read-during-write to the same word is read-first: d_rd_data returns the pre-store contents. The new value is visible to a read issued in the next cycle.
- Cycle counter:
  - 64-bit; increments by 1 every clk after reset deassertion and wraps from 2^64-1 to 0.
  - A read of CYCLE_LO returns cycle_cnt[31:0] as sampled at that edge. At the same edge, cycle_cnt[63:32] is copied into the shadow register.
  - A CYCLE_HI read returns the shadow, not the live value. Reading LO then HI therefore yields a coherent 64-bit snapshot, including across a low-word carry.
  - The shadow holds until the next CYCLE_LO read.
- Reset asserted mid-operation clears all registers immediately. A store whose clock edge coincides with rst high is lost.

Test Plan:
- Word store/load: SW 0xDEADBEEF @0x10, then read @0x10 -> d_rd_data=0xDEADBEEF one cycle after the read address; read @0x13 -> 0x000000DE.
- Byte lanes: SB 0x55 @0x21, SB 0xAA @0x22 over a word of 0x00000000 -> read @0x20 = 0x00AA5500; read @0x21 = 0x0000AA55.
- Half steering: SH 0x1234 @0x32 over 0xFFFFFFFF -> word @0x30 = 0x1234FFFF; read @0x32 = 0x00001234.
- Misaligned: SW 0x11111111 @0x41 and SH @0x43 over 0xCAFEF00D -> each pulses misalign_err for exactly 1 cycle; word @0x40 stays 0xCAFEF00D.
- Read-during-write: read @0x50 in the same cycle as SW 0x2 @0x50, holding old 0x1 -> 0x1; next read -> 0x2.
- MMIO:
  - SW 0xA5A5A5A5 to GPIO then SB 0x3C @GPIO+1 -> gpio_out=0xA5A53CA5.
  - Force cycle_cnt=0x00000000_FFFFFFFF, read CYCLE_LO then CYCLE_HI -> 0xFFFFFFFF then 0x00000000, not 1.
  - Assert rst mid-sequence -> gpio_out, d_rd_data and cycle_cnt all 0 with no clock edge.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: LSU <-> data memory bus.
//   d_we         store size: 00 none, 01 byte, 10 half, 11 word
//   d_addr       byte address, sampled every cycle
//   d_wr_data    store data, right-aligned (byte in [7:0], half in [15:0])
//   d_rd_data    right-aligned read data for the previous cycle's address
//   misalign_err one-cycle pulse after a dropped misaligned store
// master = LSU side, slave = memory side.
interface data_mem_if;
    logic [1:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        misalign_err;

    modport master (
        output d_we,
        output d_addr,
        output d_wr_data,
        input  d_rd_data,
        input  misalign_err
    );

    modport slave (
        input  d_we,
        input  d_addr,
        input  d_wr_data,
        output d_rd_data,
        output misalign_err
    );
endinterface

// File: rtl/data_mem.sv
// data_mem: single-port data RAM plus a small MMIO window, downstream of the LSU.
// Performs byte-lane steering of right-aligned store data, drops misaligned stores,
// and returns right-aligned read data one cycle after the address.
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   bus        data_mem_if slave (d_we, d_addr, d_wr_data, d_rd_data, misalign_err)
//   gpio_out   GPIO output register (MMIO reg 0)
//   cycle_cnt  live 64-bit cycle counter
// MMIO registers (d_addr[MMIO_BIT]=1, selected by d_addr[3:2]):
//   0 GPIO_OUT (rw), 1 CYCLE_LO (ro), 2 CYCLE_HI (ro, shadow), 3 reserved (reads 0)
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MMIO_BIT    = 31
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_if.slave        bus,
    output logic [31:0]      gpio_out,
    output logic [63:0]      cycle_cnt
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SzByte = 2'b01;
    localparam logic [1:0] SzHalf = 2'b10;
    localparam logic [1:0] SzWord = 2'b11;

    localparam logic [1:0] RegGpio  = 2'd0;
    localparam logic [1:0] RegCycLo = 2'd1;
    localparam logic [1:0] RegCycHi = 2'd2;
    localparam logic [1:0] RegRsvd  = 2'd3;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic [31:0] gpio_q, gpio_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;

    // Address decode
    logic [IdxW-1:0] idx;
    logic            is_mmio;
    logic [1:0]      reg_sel;
    logic [1:0]      off;

    assign idx     = bus.d_addr[IdxW+1:2];
    assign is_mmio = bus.d_addr[MMIO_BIT];
    assign reg_sel = bus.d_addr[3:2];
    assign off     = bus.d_addr[1:0];

    // Remaining address bits are aliased away.
    logic unused_addr;
    assign unused_addr = ^bus.d_addr;

    // Lane steering: replicate the right-aligned data across all lanes and let the
    // byte mask pick the lanes that actually get written.
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] st_bits;
    logic        misalign;

    always_comb begin
        st_mask  = 4'b0000;
        st_data  = 32'd0;
        misalign = 1'b0;
        case (bus.d_we)
            SzByte: begin
                st_mask = 4'b0001 << off;
                st_data = {4{bus.d_wr_data[7:0]}};
            end
            SzHalf: begin
                if (off[0]) begin
                    misalign = 1'b1;
                end else begin
                    st_mask = off[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{bus.d_wr_data[15:0]}};
                end
            end
            SzWord: begin
                if (off != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    st_mask = 4'b1111;
                    st_data = bus.d_wr_data;
                end
            end
            default: ;
        endcase
    end

    assign st_bits = {{8{st_mask[3]}}, {8{st_mask[2]}}, {8{st_mask[1]}}, {8{st_mask[0]}}};

    logic [31:0] ram_word;
    logic [31:0] ram_merged;
    logic        ram_we;
    logic        gpio_we;

    assign ram_word   = mem_q[idx];
    assign ram_merged = (ram_word & ~st_bits) | (st_data & st_bits);
    assign ram_we     = !is_mmio && (st_mask != 4'b0000);
    assign gpio_we    = is_mmio && (reg_sel == RegGpio) && (st_mask != 4'b0000);

    // Read select; uses pre-store contents so read-during-write is read-first.
    logic [31:0] rd_word;

    always_comb begin
        rd_word = 32'd0;
        if (is_mmio) begin
            unique case (reg_sel)
                RegGpio:  rd_word = gpio_q;
                RegCycLo: rd_word = cycle_q[31:0];
                RegCycHi: rd_word = shadow_q;
                RegRsvd:  rd_word = 32'd0;
            endcase
        end else begin
            rd_word = ram_word;
        end
    end

    always_comb begin
        rd_d     = rd_word >> {off, 3'b000};
        err_d    = misalign;
        gpio_d   = gpio_we ? ((gpio_q & ~st_bits) | (st_data & st_bits)) : gpio_q;
        cycle_d  = cycle_q + 64'd1;
        // Latch the high half whenever the low half is read, for a coherent LO/HI pair.
        shadow_d = (is_mmio && (reg_sel == RegCycLo)) ? cycle_q[63:32] : shadow_q;
    end

    // RAM is not reset; a store sampled while rst is high is discarded.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem_q[idx] <= ram_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= 32'd0;
            err_q    <= 1'b0;
            gpio_q   <= 32'd0;
            cycle_q  <= 64'd0;
            shadow_q <= 32'd0;
        end else begin
            rd_q     <= rd_d;
            err_q    <= err_d;
            gpio_q   <= gpio_d;
            cycle_q  <= cycle_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.d_rd_data    = rd_q;
    assign bus.misalign_err = err_q;
    assign gpio_out         = gpio_q;
    assign cycle_cnt        = cycle_q;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed scenarios plus randomized traffic for data_mem, checked every cycle
// against a byte-array reference model kept in the bench.
module tb_data_mem;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] GPIO  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] gpio_out;
    logic [63:0] cycle_cnt;

    data_mem_if bus ();

    data_mem #(
        .DEPTH_WORDS(DEPTH),
        .MMIO_BIT   (31)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_out (gpio_out),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mem_m [DEPTH*4];
    bit          valid_m [DEPTH];
    logic [31:0] gpio_m    = '0;
    logic [31:0] shadow_m  = '0;
    logic [63:0] cnt_m     = '0;
    logic [31:0] exp_rd    = '0;
    bit          exp_known = 1'b1;
    bit          exp_err   = 1'b0;
    bit          model_on  = 1'b0;

    function automatic logic [31:0] word_of(input int w);
        return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
    endfunction

    task automatic model_reset();
        exp_rd    = '0;
        exp_known = 1'b1;
        exp_err   = 1'b0;
        gpio_m    = '0;
        cnt_m     = '0;
        shadow_m  = '0;
    endtask

    task automatic model_step();
        logic [31:0] a, wd, sel;
        logic [1:0]  we, r;
        int          off, w, nb, base, lane;
        bit          mm, mis;
        a   = bus.d_addr;
        we  = bus.d_we;
        wd  = bus.d_wr_data;
        off = int'(a[1:0]);
        mm  = a[31];
        r   = a[3:2];
        w   = int'((a >> 2) % DEPTH);
        if (mm) begin
            exp_known = 1'b1;
            case (r)
                2'd0:    sel = gpio_m;
                2'd1:    sel = cnt_m[31:0];
                2'd2:    sel = shadow_m;
                default: sel = 32'd0;
            endcase
            if (r == 2'd1) shadow_m = cnt_m[63:32];
        end else begin
            sel       = word_of(w);
            exp_known = valid_m[w];
        end
        exp_rd = sel >> (8 * off);
        nb = (we == 2'd1) ? 1 : (we == 2'd2) ? 2 : (we == 2'd3) ? 4 : 0;
        mis = (nb > 1) && ((off % nb) != 0);
        exp_err = mis;
        if (nb > 0 && !mis) begin
            base = off - (off % nb);
            for (int k = 0; k < nb; k++) begin
                lane = base + k;
                if (mm) begin
                    if (r == 2'd0) gpio_m[8*lane +: 8] = wd[8*k +: 8];
                end else begin
                    mem_m[4*w + lane] = wd[8*k +: 8];
                end
            end
            if (nb == 4 && !mm) valid_m[w] = 1'b1;
        end
        cnt_m = cnt_m + 64'd1;
    endtask

    // Single compare process: model advances at each edge, outputs checked just after.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
            #1;
            if (model_on) begin
                if (exp_known) chk("rd_data", {32'd0, bus.d_rd_data}, {32'd0, exp_rd});
                chk("misalign_err", {63'd0, bus.misalign_err}, {63'd0, exp_err});
                chk("gpio_out", {32'd0, gpio_out}, {32'd0, gpio_m});
                chk("cycle_cnt", cycle_cnt, cnt_m);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [1:0] we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_we      = we;
        bus.d_addr    = a;
        bus.d_wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.d_we      = 2'b00;
        bus.d_addr    = 32'd0;
        bus.d_wr_data = 32'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_rd", {32'd0, bus.d_rd_data}, 64'd0);
        chk("rst_err", {63'd0, bus.misalign_err}, 64'd0);
        chk("rst_gpio", {32'd0, gpio_out}, 64'd0);
        chk("rst_cnt", cycle_cnt, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        model_on = 1'b1;

        // Fill RAM so every word has a known value.
        for (int i = 0; i < DEPTH; i++) cyc(2'b11, 32'(i * 4), $urandom);

        // Word store/load
        cyc(2'b11, 32'h10, 32'hDEAD_BEEF);
        cyc(2'b00, 32'h10, 32'h0);
        chk("sw_lw", {32'd0, bus.d_rd_data}, 64'hDEAD_BEEF);
        cyc(2'b00, 32'h13, 32'h0);
        chk("lw_off3", {32'd0, bus.d_rd_data}, 64'h0000_00DE);

        // Byte lanes (upper data bits are garbage and must be ignored)
        cyc(2'b11, 32'h20, 32'h0);
        cyc(2'b01, 32'h21, 32'hFFFF_FF55);
        cyc(2'b01, 32'h22, 32'h1234_56AA);
        cyc(2'b00, 32'h20, 32'h0);
        chk("sb_word", {32'd0, bus.d_rd_data}, 64'h00AA_5500);
        cyc(2'b00, 32'h21, 32'h0);
        chk("sb_off1", {32'd0, bus.d_rd_data}, 64'h0000_AA55);

        // Half steering
        cyc(2'b11, 32'h30, 32'hFFFF_FFFF);
        cyc(2'b10, 32'h32, 32'hABCD_1234);
        cyc(2'b00, 32'h30, 32'h0);
        chk("sh_word", {32'd0, bus.d_rd_data}, 64'h1234_FFFF);
        cyc(2'b00, 32'h32, 32'h0);
        chk("sh_off2", {32'd0, bus.d_rd_data}, 64'h0000_1234);

        // Misaligned stores
        cyc(2'b11, 32'h40, 32'hCAFE_F00D);
        cyc(2'b11, 32'h41, 32'h1111_1111);
        chk("mis_sw_err", {63'd0, bus.misalign_err}, 64'd1);
        cyc(2'b00, 32'h40, 32'h0);
        chk("mis_sw_clr", {63'd0, bus.misalign_err}, 64'd0);
        chk("mis_sw_kept", {32'd0, bus.d_rd_data}, 64'hCAFE_F00D);
        cyc(2'b10, 32'h43, 32'h0000_2222);
        chk("mis_sh_err", {63'd0, bus.misalign_err}, 64'd1);
        cyc(2'b00, 32'h40, 32'h0);
        chk("mis_sh_clr", {63'd0, bus.misalign_err}, 64'd0);
        chk("mis_sh_kept", {32'd0, bus.d_rd_data}, 64'hCAFE_F00D);

        // Read-during-write is read-first
        cyc(2'b11, 32'h50, 32'h1);
        cyc(2'b11, 32'h50, 32'h2);
        chk("rdw_old", {32'd0, bus.d_rd_data}, 64'h1);
        cyc(2'b00, 32'h50, 32'h0);
        chk("rdw_new", {32'd0, bus.d_rd_data}, 64'h2);

        // GPIO
        cyc(2'b11, GPIO, 32'hA5A5_A5A5);
        chk("gpio_sw", {32'd0, gpio_out}, 64'hA5A5_A5A5);
        cyc(2'b01, GPIO + 32'd1, 32'h0000_003C);
        chk("gpio_sb", {32'd0, gpio_out}, 64'hA5A5_3CA5);
        cyc(2'b00, GPIO + 32'd2, 32'h0);
        chk("gpio_rd_off2", {32'd0, bus.d_rd_data}, 64'h0000_A5A5);
        cyc(2'b11, GPIO + 32'd12, 32'hFFFF_FFFF);
        chk("rsvd_no_err", {63'd0, bus.misalign_err}, 64'd0);

        // Cycle counter LO/HI coherence across a low-word carry
        model_on = 1'b0;
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        cyc(2'b00, GPIO + 32'd4, 32'h0);
        chk("cyc_lo", {32'd0, bus.d_rd_data}, 64'hFFFF_FFFF);
        force dut.cycle_q = 64'h0000_0001_0000_0000;
        cyc(2'b00, GPIO + 32'd8, 32'h0);
        chk("cyc_hi_shadow", {32'd0, bus.d_rd_data}, 64'h0);
        release dut.cycle_q;

        // Asynchronous reset mid-sequence, then stores during reset are lost
        cyc(2'b11, GPIO, 32'h1234_5678);
        #1 rst = 1'b1;
        model_on = 1'b1;
        #1;
        chk("arst_gpio", {32'd0, gpio_out}, 64'd0);
        chk("arst_rd", {32'd0, bus.d_rd_data}, 64'd0);
        chk("arst_cnt", cycle_cnt, 64'd0);
        cyc(2'b11, GPIO, 32'hFFFF_FFFF);
        chk("rst_store_gpio", {32'd0, gpio_out}, 64'd0);
        cyc(2'b11, 32'h60, 32'h0000_0077);
        rst = 1'b0;
        cyc(2'b00, 32'h60, 32'h0);
        chk("cnt_after_rst", cycle_cnt, 64'd1);

        // Randomized traffic, including aliased RAM addresses and MMIO with stray bits
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            else a[31] = 1'b0;
            cyc(2'($urandom_range(0, 3)), a, $urandom);
        end
        cyc(2'b00, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
